// File: rtl/spi_slave_sync_pkg.sv
// Shared constants for the clk-domain SPI slave: FSM encoding, MODE bit positions
// and byte geometry.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int BYTE_W   = 8;
  localparam int CNT_W    = 3;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_slave_sync_if.sv
// Bundle of SPI pins and byte handshakes around spi_slave_sync.
// Handshake rule (both byte channels): a transfer happens on a rising clk edge
// where valid && ready; valid holds its data until then, ready may toggle freely.
interface spi_slave_sync_if;
  import spi_pkg::*;

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic [1:0]        mode;
  logic              miso;
  logic              miso_oe;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              tx_underrun;
  logic              rx_overrun;

  modport master (
    output sclk, cs_n, mosi, mode, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );

  modport slave (
    input  sclk, cs_n, mosi, mode, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable reset level
// so each pin can come out of reset at its inactive value.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  // Depth below two is not metastability-safe, so it is clamped.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {N{rst_val_i}};
    else        sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave fully inside the clk domain: pins are oversampled through synchronizers,
// sclk edges are detected in clk, bytes move through single-entry TX/RX buffers.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic [1:0]        MODE,
  output logic              miso,
  output logic              miso_oe,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              tx_underrun,
  output logic              rx_overrun
);

  logic sclk_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(reset), .rst_val_i(1'b0), .d_i(sclk), .q_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(reset), .rst_val_i(1'b1), .d_i(cs_n), .q_o(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .rst_val_i(1'b0), .d_i(mosi), .q_o(mosi_s)
  );

  state_e              state_q, state_d;
  logic                sclk_prev_q, cs_prev_q;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [BYTE_W-1:0]   tx_sr_q;
  logic [BYTE_W-2:0]   rx_sr_q;
  logic [BYTE_W-1:0]   hold_q;
  logic                hold_full_q;
  logic [BYTE_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                underrun_q, overrun_q;

  logic                active, sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                lead_edge, trail_edge, sample_edge, shift_edge;
  logic                start, load_now, shift_now, byte_done, tx_wr;
  logic [BYTE_W-1:0]   rx_byte;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q == ST_ACTIVE);
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_fall   = cs_prev_q & ~cs_s;
    cs_rise   = ~cs_prev_q & cs_s;
    // A deselect in the same cycle as an sclk edge wins; the edge is dropped.
    lead_edge  = active & ~cs_rise & (mode_q[CPOL_BIT] ? sclk_fall : sclk_rise);
    trail_edge = active & ~cs_rise & (mode_q[CPOL_BIT] ? sclk_rise : sclk_fall);
    sample_edge = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
    shift_edge  = mode_q[CPHA_BIT] ? lead_edge  : trail_edge;
    start     = ~active & cs_fall;
    // bit_cnt==0 on a shift edge means a byte boundary, so a fresh byte is loaded.
    load_now  = (start & ~MODE[CPHA_BIT]) | (shift_edge & (bit_cnt_q == '0));
    shift_now = shift_edge & (bit_cnt_q != '0);
    byte_done = sample_edge & (bit_cnt_q == CNT_W'(BYTE_W - 1));
    rx_byte   = {rx_sr_q, mosi_s};
    tx_wr     = tx_valid & ~hold_full_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      mode_q      <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;

      if (start) begin
        mode_q    <= MODE;
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
      end else if (active && cs_rise) begin
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
      end else if (sample_edge) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        rx_sr_q   <= rx_byte[BYTE_W-2:0];
      end

      if (load_now) begin
        tx_sr_q    <= hold_full_q ? hold_q : IDLE_FILL;
        underrun_q <= ~hold_full_q;
      end else if (shift_now) begin
        tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
      end

      // tx_wr needs an empty holding register and a load only drains a full one.
      if (tx_wr) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (load_now) begin
        hold_full_q <= 1'b0;
      end

      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (byte_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= rx_byte;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign busy        = active;
  assign miso_oe     = active;
  assign miso        = tx_sr_q[BYTE_W-1];
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a table of single-byte transfers in all four
// modes, then hand-written back-to-back, abort and reset sequences.
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_sync_if bus();

  spi_slave_sync #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .reset(rst_n),
    .sclk(bus.sclk), .cs_n(bus.cs_n), .mosi(bus.mosi), .MODE(bus.mode),
    .miso(bus.miso), .miso_oe(bus.miso_oe),
    .tx_data(bus.tx_data), .tx_valid(bus.tx_valid), .tx_ready(bus.tx_ready),
    .rx_data(bus.rx_data), .rx_valid(bus.rx_valid), .rx_ready(bus.rx_ready),
    .busy(bus.busy), .tx_underrun(bus.tx_underrun), .rx_overrun(bus.rx_overrun)
  );

  typedef struct {
    logic [1:0] mode;
    logic       queued;
    logic [7:0] tx_byte;
    logic [7:0] mosi_byte;
    logic [7:0] exp_miso;
    int         exp_underrun;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  int         underrun_cnt = 0;
  int         overrun_cnt = 0;
  int         rxv_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.tx_underrun) underrun_cnt++;
    if (bus.rx_overrun)  overrun_cnt++;
    if (bus.rx_valid)    rxv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, " miso"},        32'(bus.miso), 0);
    check({p, " miso_oe"},     32'(bus.miso_oe), 0);
    check({p, " busy"},        32'(bus.busy), 0);
    check({p, " rx_valid"},    32'(bus.rx_valid), 0);
    check({p, " rx_data"},     32'(bus.rx_data), 0);
    check({p, " tx_ready"},    32'(bus.tx_ready), 1);
    check({p, " tx_underrun"}, 32'(bus.tx_underrun), 0);
    check({p, " rx_overrun"},  32'(bus.rx_overrun), 0);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    cycles(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_start(input logic [1:0] mode);
    bus.cs_n = 1'b1;
    bus.mode = mode;
    bus.sclk = mode[1];
    cycles(8);
    bus.cs_n = 1'b0;
    cycles(HALF);
  endtask

  task automatic cs_stop();
    cycles(HALF);
    bus.cs_n = 1'b1;
    cycles(6);
  endtask

  // Master side of nbits bit-times; rx collects miso as the master samples it.
  // pulse_last raises rx_ready for exactly the clk cycle in which the slave acts on
  // the final sampling edge (two sync flops plus the edge-detect cycle).
  task automatic xfer(input logic [1:0] mode, input logic [7:0] tx, input int nbits,
                      input bit pulse_last, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    rx   = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      if (!cpha) begin
        bus.mosi = tx[i];
        cycles(HALF);
        rx[i]    = bus.miso;
        bus.sclk = ~cpol;
        if (pulse_last && i == 0) begin
          cycles(2);
          bus.rx_ready = 1'b1;
          cycles(1);
          bus.rx_ready = 1'b0;
          cycles(HALF - 3);
        end else begin
          cycles(HALF);
        end
        bus.sclk = cpol;
      end else begin
        cycles(HALF);
        bus.sclk = ~cpol;
        bus.mosi = tx[i];
        cycles(HALF);
        rx[i]    = bus.miso;
        bus.sclk = cpol;
      end
    end
  endtask

  task automatic rx_take(input string name, input bit consume);
    logic [7:0] want;
    int n;
    n = 0;
    while (!bus.rx_valid && n < 40) begin
      cycles(1);
      n++;
    end
    check({name, " rx_valid"}, 32'(bus.rx_valid), 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected rx byte %0h, required none", name, bus.rx_data);
    end else begin
      want = exp_q.pop_front();
      check({name, " rx_data"}, 32'(bus.rx_data), 32'(want));
    end
    if (consume) begin
      bus.rx_ready = 1'b1;
      cycles(1);
      bus.rx_ready = 1'b0;
      check({name, " rx_valid clear"}, 32'(bus.rx_valid), 0);
    end
  endtask

  initial begin
    logic [7:0] got;
    int o0, r0;

    // underrun counts include the reload after the byte in CPHA=0 modes
    vecs[0] = '{mode: 2'd0, queued: 1'b1, tx_byte: 8'hA5, mosi_byte: 8'h3C, exp_miso: 8'hA5, exp_underrun: 1};
    vecs[1] = '{mode: 2'd1, queued: 1'b1, tx_byte: 8'h81, mosi_byte: 8'h7E, exp_miso: 8'h81, exp_underrun: 0};
    vecs[2] = '{mode: 2'd2, queued: 1'b1, tx_byte: 8'h81, mosi_byte: 8'h7E, exp_miso: 8'h81, exp_underrun: 1};
    vecs[3] = '{mode: 2'd3, queued: 1'b1, tx_byte: 8'h81, mosi_byte: 8'h7E, exp_miso: 8'h81, exp_underrun: 0};
    vecs[4] = '{mode: 2'd0, queued: 1'b0, tx_byte: 8'h00, mosi_byte: 8'h55, exp_miso: 8'hFF, exp_underrun: 2};
    vecs[5] = '{mode: 2'd3, queued: 1'b0, tx_byte: 8'h00, mosi_byte: 8'h55, exp_miso: 8'hFF, exp_underrun: 1};

    rst_n        = 1'b0;
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.mode     = 2'd0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    cycles(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    cycles(4);

    for (int v = 0; v < 6; v++) begin
      int u0;
      bus.mode = vecs[v].mode;
      bus.sclk = vecs[v].mode[1];
      cycles(8);
      if (vecs[v].queued) begin
        queue_tx(vecs[v].tx_byte);
        check($sformatf("v%0d tx_ready full", v), 32'(bus.tx_ready), 0);
      end
      u0 = underrun_cnt;
      exp_q.push_back(vecs[v].mosi_byte);
      cs_start(vecs[v].mode);
      check($sformatf("v%0d busy", v), 32'(bus.busy), 1);
      check($sformatf("v%0d miso_oe", v), 32'(bus.miso_oe), 1);
      xfer(vecs[v].mode, vecs[v].mosi_byte, 8, 1'b0, got);
      rx_take($sformatf("v%0d", v), 1'b1);
      check($sformatf("v%0d miso bits", v), 32'(got), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d tx_ready after load", v), 32'(bus.tx_ready), 1);
      cs_stop();
      check($sformatf("v%0d busy after", v), 32'(bus.busy), 0);
      check($sformatf("v%0d miso_oe after", v), 32'(bus.miso_oe), 0);
      check($sformatf("v%0d underrun pulses", v), 32'(underrun_cnt - u0), 32'(vecs[v].exp_underrun));
    end

    // Back-to-back with rx_ready low: the second byte is dropped with an overrun.
    o0 = overrun_cnt;
    exp_q.push_back(8'h11);
    cs_start(2'd0);
    xfer(2'd0, 8'h11, 8, 1'b0, got);
    check("b2b first byte", 32'(bus.rx_data), 32'h11);
    xfer(2'd0, 8'h22, 8, 1'b0, got);
    cycles(4);
    check("b2b overrun pulses", 32'(overrun_cnt - o0), 1);
    rx_take("b2b keep", 1'b1);
    cs_stop();
    check("b2b dropped byte", 32'(bus.rx_valid), 0);

    // Same again, rx_ready in the completion cycle: old byte accepted, new one loaded.
    o0 = overrun_cnt;
    exp_q.push_back(8'h22);
    cs_start(2'd0);
    xfer(2'd0, 8'h11, 8, 1'b0, got);
    check("b2b2 first byte", 32'(bus.rx_data), 32'h11);
    xfer(2'd0, 8'h22, 8, 1'b1, got);
    cycles(4);
    check("b2b2 overrun pulses", 32'(overrun_cnt - o0), 0);
    rx_take("b2b2 new", 1'b1);
    cs_stop();

    // Deselect after 5 bits.
    r0 = rxv_cnt;
    cs_start(2'd0);
    xfer(2'd0, 8'hF0, 5, 1'b0, got);
    cycles(HALF);
    bus.cs_n = 1'b1;
    cycles(2);
    check("abort oe during detect", 32'(bus.miso_oe), 1);
    cycles(1);
    check("abort oe dropped", 32'(bus.miso_oe), 0);
    cycles(10);
    check("abort no rx_valid", 32'(rxv_cnt - r0), 0);
    check("abort busy", 32'(bus.busy), 0);
    exp_q.push_back(8'hC3);
    cs_start(2'd0);
    xfer(2'd0, 8'hC3, 8, 1'b0, got);
    rx_take("after abort", 1'b0);
    cs_stop();

    // Reset after 3 bits with rx_valid still high and the holding register full.
    queue_tx(8'h5A);
    cs_start(2'd0);
    queue_tx(8'h33);
    check("pre-reset tx_ready", 32'(bus.tx_ready), 0);
    xfer(2'd0, 8'hE7, 3, 1'b0, got);
    cycles(3);
    check("pre-reset miso", 32'(bus.miso), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid reset");
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    cycles(8);
    check("post-reset rx_valid", 32'(bus.rx_valid), 0);
    check("post-reset busy", 32'(bus.busy), 0);
    queue_tx(8'h69);
    exp_q.push_back(8'h96);
    cs_start(2'd0);
    xfer(2'd0, 8'h96, 8, 1'b0, got);
    rx_take("post-reset", 1'b1);
    check("post-reset miso bits", 32'(got), 32'h69);
    cs_stop();
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, flops per input synchronizer (minimum 2).
REQ-002 SHALL have parameter: IDLE_FILL, 8'hFF, byte shifted out when no TX byte is queued.
REQ-003 SHALL have port: clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: sclk, cs_n, mosi  input  1 each  asynchronous SPI pins from master.
REQ-006 SHALL have port: MODE  input  2  {CPOL,CPHA}.
REQ-007 SHALL have ports: miso  output  1  serial data; miso_oe  output  1  drive enable for external tristate.
REQ-008 SHALL have ports: tx_data  input  8; tx_valid  input  1; tx_ready  output  1  (TX byte handshake).
REQ-009 SHALL have ports: rx_data  output  8; rx_valid  output  1; rx_ready  input  1  (RX byte handshake).
REQ-010 SHALL have ports: busy  output  1  (transaction active); tx_underrun, rx_overrun  output  1  (one-cycle pulses).

Function
REQ-011 SHALL pass sclk, cs_n and mosi through SYNC_STAGES-flop synchronizers; edges detected from last two synchronized samples; supported sclk <= clk/8.
REQ-012 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synchronized cs_n falling; ACTIVE->IDLE on synchronized cs_n rising; busy = (state==ACTIVE).
REQ-013 SHALL capture MODE on IDLE->ACTIVE; MODE changes during ACTIVE are ignored.
REQ-014 SHALL define leading edge as sclk leaving CPOL level, trailing edge as returning to it.
REQ-015 SHALL transfer 8-bit bytes MSB first, 3-bit bit counter wrapping 7->0; consecutive bytes with cs_n held low SHALL be back-to-back.
REQ-016 CPHA=0: sample mosi on leading edge, shift miso on trailing edge; byte load at cs_n fall and on trailing edge after bit 0.
REQ-017 CPHA=1: shift miso on leading edge (first leading edge of a byte loads it), sample mosi on trailing edge.
REQ-018 Byte load SHALL take the TX holding byte if full (holding emptied) else IDLE_FILL with tx_underrun pulse in the same cycle.
REQ-019 tx_ready SHALL be high when the single-entry holding register is empty; tx_valid&&tx_ready writes it; tx_valid while full is ignored.
REQ-020 On the clk cycle after the 8th sampling edge is detected, completed byte SHALL go to rx_data with rx_valid high, held until rx_valid&&rx_ready.
REQ-021 If a byte completes while rx_valid is still high, new byte SHALL be dropped, rx_data unchanged, rx_overrun pulsed one cycle; simultaneous rx_ready in that cycle SHALL accept the old byte and load the new one, no overrun.
REQ-022 cs_n rising mid-byte SHALL discard partial RX bits (no rx_valid), clear bit counter, not restore the consumed TX byte.
REQ-023 miso_oe SHALL be high only in ACTIVE and drop the cycle after synchronized cs_n rise; miso = shift-register MSB.
REQ-024 sclk edges while IDLE SHALL be ignored.

Reset
REQ-025 On reset low, asynchronously: state IDLE, miso 0, miso_oe 0, busy 0, rx_valid 0, rx_data 8'h00, tx_ready 1, tx_underrun 0, rx_overrun 0, counters and shift registers 0, synchronizers to cs_n=1, sclk=0, mosi=0.
REQ-026 Reset asserted mid-transaction SHALL abort without rx_valid; after release, block waits for a fresh cs_n falling edge.

Structure
REQ-027 SHALL place state encoding, MODE bit positions (CPOL=bit1, CPHA=bit0) and byte width constant in shared package spi_pkg.
REQ-028 SHALL use one sub-module spi_sync (parameterized-depth synchronizer with reset value input), instantiated three times.

Verification
REQ-029 Mode 0, tx byte 8'hA5 queued, master sends 8'h3C at clk/8 -> miso bits 10100101, rx_data 8'h3C with rx_valid, tx_ready re-high after load.
REQ-030 Modes 1, 2, 3 each with tx 8'h81, master 8'h7E -> correct bits per edge rule, rx_data 8'h7E.
REQ-031 Nothing queued, master sends 8'h55 -> miso shifts 8'hFF, tx_underrun one pulse at load, rx_data 8'h55.
REQ-032 Two back-to-back bytes 8'h11, 8'h22, rx_ready held low -> rx_data 8'h11 kept, rx_overrun pulse at 2nd completion; repeat with rx_ready pulsed same cycle -> rx_data 8'h22, no overrun.
REQ-033 cs_n raised after 5 bits -> no rx_valid, miso_oe low next cycle; next full byte 8'hC3 received correctly.
REQ-034 reset asserted after 3 bits of a byte -> all outputs to REQ-025 values immediately; post-reset byte 8'h96 transferred correctly.
